// File: rtl/axis_result_drain_fifo.sv
// Result-word drain FIFO: buffers MAC_NUM x 5-bit result words and serialises
// each word onto an AXI4-Stream master, six values per 32-bit beat, with framed tlast.
module axis_result_drain_fifo #(
  parameter int C_M_AXIS_TDATA_WIDTH  = 32,
  parameter int MAC_NUM               = 256,
  parameter int AXIS_DRAIN_FIFO_DEPTH = 4,
  parameter int bit_num               = $clog2(AXIS_DRAIN_FIFO_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [5*MAC_NUM-1:0]            ofmaps_in,
  input  logic                            load_ofmaps,
  input  logic [11:0]                     output_channel_size,
  input  logic [15:0]                     frame_words,
  input  logic                            axis_clear,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [bit_num:0]                fifo_cnt,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic                            frame_done
);

  localparam int WW    = 5 * MAC_NUM;
  localparam int DEPTH = AXIS_DRAIN_FIFO_DEPTH;

  logic [WW-1:0]      mem_q [DEPTH];
  logic [bit_num-1:0] rptr_q, wptr_q;
  logic [bit_num:0]   cnt_q;
  logic [11:0]        v_q;
  logic [15:0]        w_q;
  logic               frame_done_q;

  logic                            hs, pop, push, last_beat, tlast_c;
  logic [15:0]                     fw_last;
  logic [WW-1:0]                   rd_word;
  logic [29:0]                     lanes;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_c;

  always_comb begin
    fifo_empty    = (cnt_q == '0);
    fifo_full     = (cnt_q == (bit_num+1)'(DEPTH));
    m_axis_tvalid = ~fifo_empty;
    hs            = m_axis_tvalid & m_axis_tready;
    last_beat     = ({1'b0, v_q} + 13'd6) >= {1'b0, output_channel_size};
    fw_last       = (frame_words == '0) ? '0 : frame_words - 16'd1;
    tlast_c       = last_beat & (w_q == fw_last) & m_axis_tvalid;
    pop           = hs & last_beat;
    push          = load_ofmaps & (~fifo_full | pop);

    // Word is barrel-shifted so the current beat's six values land in the low 30 bits.
    rd_word = mem_q[rptr_q];
    lanes   = 30'(rd_word >> (v_q * 12'd5));
    tdata_c = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (({1'b0, v_q} + 13'(k)) < {1'b0, output_channel_size})
        tdata_c[5*k +: 5] = lanes[5*k +: 5];
    end
    if (!m_axis_tvalid) tdata_c = '0;
  end

  assign m_axis_tdata = tdata_c;
  assign m_axis_tlast = tlast_c;
  assign fifo_cnt     = cnt_q;
  assign frame_done   = frame_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      v_q          <= '0;
      w_q          <= '0;
      frame_done_q <= 1'b0;
    end else if (axis_clear) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      v_q          <= '0;
      w_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= ofmaps_in;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (hs) v_q <= last_beat ? '0 : v_q + 12'd6;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        w_q    <= tlast_c ? '0 : w_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      frame_done_q <= pop & tlast_c;
    end
  end

endmodule
